// File: rtl/avalon_pio_hs_pkg.sv
// rtl/avalon_pio_hs_pkg.sv - register map offsets, status field indices and parameter checks
package avalon_pio_hs_pkg;

  localparam int REG_W = 32;

  function automatic int data_off(input int ch);
    return ch;
  endfunction

  function automatic int status_off(input int num_ch);
    return num_ch;
  endfunction

  function automatic int mask_off(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int valid_idx(input int ch);
    return ch;
  endfunction

  function automatic int ovr_idx(input int num_ch, input int ch);
    return num_ch + ch;
  endfunction

  function automatic int done_idx(input int num_ch, input int ch);
    return 2 * num_ch + ch;
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w >= 1) && (w <= REG_W);
  endfunction

  function automatic bit num_ch_ok(input int n, input int addr_w);
    return (n >= 1) && (n <= (1 << addr_w) - 2);
  endfunction

endpackage

// File: rtl/pio_hs_channel.sv
// rtl/pio_hs_channel.sv - one channel: data register, valid/ready handshake, sticky overrun and done
// Optional done tracking under AVALON_PIO_HS_IRQ_EN.
module pio_hs_channel #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  input  logic              ovr_clr_i,
  input  logic              done_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ovr_o,
  output logic              done_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  // A load during a transfer keeps valid high; only a load onto an unaccepted word is an overrun.
  always_comb begin
    data_d  = load_i ? load_data_i : data_q;
    valid_d = load_i | (valid_q & ~ready_i);
    ovr_d   = (load_i & valid_q & ~ready_i) | (ovr_q & ~ovr_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

`ifdef AVALON_PIO_HS_IRQ_EN
  logic done_q, done_d;

  assign done_d = (valid_q & ready_i) | (done_q & ~done_clr_i);

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done_o = done_q;
`else
  logic unused_done_clr;
  assign unused_done_clr = done_clr_i;
  assign done_o          = 1'b0;
`endif

endmodule

// File: rtl/avalon_pio_handshake.sv
// rtl/avalon_pio_handshake.sv - Avalon-MM multi-channel PIO with valid/ready outputs
// AVALON_PIO_HS_IRQ_EN enables done status, IRQ_MASK and the irq output.
module avalon_pio_handshake
  import avalon_pio_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        in_ready,
  output logic                     irq
);

  if (!data_w_ok(DATA_W) || !num_ch_ok(NUM_CH, ADDR_W)) begin : g_bad_params
    $error("avalon_pio_handshake: illegal DATA_W/NUM_CH/ADDR_W combination");
  end

  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(status_off(NUM_CH));
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(mask_off(NUM_CH));

  // Status fields may sit above bit 31 for wide configurations; those bits are never writable.
  function automatic logic wbit(input logic [31:0] w, input int idx);
    return (idx < REG_W) ? w[idx[4:0]] : 1'b0;
  endfunction

  logic                  wr, status_wr;
  logic [NUM_CH-1:0]     load, ovr_clr, done_clr, ovr, done;
  logic [3*NUM_CH-1:0]   status;
  logic [31:0]           rdata;

  assign wr        = chipselect & ~write_n;
  assign status_wr = wr && (address == A_STATUS);

  always_comb begin
    load     = '0;
    ovr_clr  = '0;
    done_clr = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      load[ch]     = wr && (address == ADDR_W'(data_off(ch)));
      ovr_clr[ch]  = status_wr & wbit(writedata, ovr_idx(NUM_CH, ch));
      done_clr[ch] = status_wr & wbit(writedata, done_idx(NUM_CH, ch));
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pio_hs_channel #(.DATA_W(DATA_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load[ch]),
      .load_data_i(writedata[DATA_W-1:0]),
      .ready_i    (in_ready[ch]),
      .ovr_clr_i  (ovr_clr[ch]),
      .done_clr_i (done_clr[ch]),
      .data_o     (out_data[ch*DATA_W +: DATA_W]),
      .valid_o    (out_valid[ch]),
      .ovr_o      (ovr[ch]),
      .done_o     (done[ch])
    );
  end

  assign status = {done, ovr, out_valid};

`ifdef AVALON_PIO_HS_IRQ_EN
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr && (address == A_MASK)) begin
      for (int ch = 0; ch < NUM_CH; ch++) mask_d[ch] = wbit(writedata, ch);
    end
    irq_d = |(done & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (address == ADDR_W'(data_off(ch))) rdata = 32'(out_data[ch*DATA_W +: DATA_W]);
    end
    if (address == A_STATUS) rdata = 32'(status);
`ifdef AVALON_PIO_HS_IRQ_EN
    if (address == A_MASK) rdata = 32'(mask_q);
`endif
  end

  assign readdata = rdata;

endmodule

// File: tb/tb_avalon_pio_handshake.sv
// tb/tb_avalon_pio_handshake.sv - directed and randomized checks against a behavioural register model
module tb_avalon_pio_handshake;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;
`ifdef AVALON_PIO_HS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            chipselect;
  logic            write_n;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    in_ready;
  logic            irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_data [N];
  bit          m_valid[N];
  bit          m_ovr  [N];
  bit          m_done [N];
  logic [N-1:0] m_mask;
  bit          m_irq;

  avalon_pio_handshake #(.DATA_W(DW), .NUM_CH(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference: apply one clock edge of register-map semantics to the model.
  task automatic model_update();
    bit wr;
    bit nxt_irq;
    wr = chipselect && !write_n;
    nxt_irq = 1'b0;
    for (int ch = 0; ch < N; ch++) if (m_done[ch] && m_mask[ch]) nxt_irq = 1'b1;
    if (reset) begin
      for (int ch = 0; ch < N; ch++) begin
        m_data[ch] = '0; m_valid[ch] = 0; m_ovr[ch] = 0; m_done[ch] = 0;
      end
      m_mask = '0;
      m_irq  = 0;
      return;
    end
    for (int ch = 0; ch < N; ch++) begin
      bit xfer, loading;
      xfer    = m_valid[ch] && in_ready[ch];
      loading = wr && (int'(address) == ch);
      if (wr && int'(address) == N && writedata[N+ch])   m_ovr[ch]  = 0;
      if (wr && int'(address) == N && writedata[2*N+ch]) m_done[ch] = 0;
      if (loading && m_valid[ch] && !in_ready[ch]) m_ovr[ch] = 1;
      if (xfer && IRQ_EN) m_done[ch] = 1;
      if (loading) begin
        m_data[ch]  = writedata;
        m_valid[ch] = 1;
      end else if (xfer) begin
        m_valid[ch] = 0;
      end
    end
    if (IRQ_EN && wr && int'(address) == N + 1) m_mask = writedata[N-1:0];
    m_irq = IRQ_EN ? nxt_irq : 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] r;
    r = '0;
    if (int'(a) < N) begin
      r = m_data[a];
    end else if (int'(a) == N) begin
      for (int ch = 0; ch < N; ch++) begin
        r[ch]       = m_valid[ch];
        r[N+ch]     = m_ovr[ch];
        r[2*N+ch]   = m_done[ch];
      end
    end else if (int'(a) == N + 1 && IRQ_EN) begin
      r[N-1:0] = m_mask;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N*DW-1:0] ed;
    logic [N-1:0]    ev;
    for (int ch = 0; ch < N; ch++) begin
      ed[ch*DW +: DW] = m_data[ch];
      ev[ch]          = m_valid[ch];
    end
    chk({tag, "_valid"}, out_valid, ev);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_irq"}, irq, m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    chipselect = 0; write_n = 1; address = '0; writedata = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    step();
    idle();
    check_outputs("wr");
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a);
    chipselect = 1; write_n = 1; address = a;
    #1;
    chk(tag, readdata, model_read(a));
  endtask

  initial begin
    reset = 1; in_ready = '0; idle();
    step(); step();
    reset = 0;
    check_outputs("rst");
    chk("rst_valid_c", out_valid, 4'h0);
    read_chk("rst_status", 3'(N));

    // 1: load ch0 and hold it with ready low
    do_write(3'd0, 32'hA5);
    chk("t1_valid", out_valid[0], 1'b1);
    chk("t1_byte", out_data[7:0], 8'hA5);
    for (int i = 0; i < 10; i++) begin
      step();
      check_outputs("t1_hold");
      chk("t1_hold_byte", out_data[7:0], 8'hA5);
    end

    // 2: single-cycle accept
    in_ready = 4'b0001;
    step();
    in_ready = '0;
    check_outputs("t2");
    chk("t2_valid", out_valid[0], 1'b0);
    read_chk("t2_status", 3'(N));
    chk("t2_status_c", readdata, IRQ_EN ? 32'h100 : 32'h0);
    idle();

    // 3: overrun then W1C
    do_write(3'd1, 32'h11);
    do_write(3'd1, 32'h22);
    chk("t3_data", out_data[63:32], 32'h22);
    read_chk("t3_status", 3'(N));
    chk("t3_ovr", readdata[N+1], 1'b1);
    do_write(3'(N), 32'(1) << (N + 1));
    read_chk("t3_status_clr", 3'(N));
    chk("t3_ovr_clr", readdata[N+1], 1'b0);
    idle();

    // 4: write landing on the transfer cycle
    do_write(3'd2, 32'h44);
    chipselect = 1; write_n = 0; address = 3'd2; writedata = 32'h33; in_ready = 4'b0100;
    step();
    idle(); in_ready = '0;
    check_outputs("t4");
    chk("t4_valid", out_valid[2], 1'b1);
    chk("t4_data", out_data[95:64], 32'h33);
    read_chk("t4_status", 3'(N));
    chk("t4_ovr", readdata[N+2], 1'b0);
    idle();

`ifdef AVALON_PIO_HS_IRQ_EN
    // 5: done/mask/irq path
    do_write(3'(N + 1), 32'h1);
    do_write(3'd0, 32'h55);
    in_ready = 4'b0001; step(); in_ready = '0;
    step(); check_outputs("t5_a");
    chk("t5_irq_on", irq, 1'b1);
    do_write(3'(N), 32'(1) << (2 * N));
    step(); check_outputs("t5_b");
    chk("t5_irq_off", irq, 1'b0);
    in_ready = 4'b0010; step(); in_ready = '0;
    step(); step(); check_outputs("t5_c");
    chk("t5_irq_ch1", irq, 1'b0);
`endif

    // 6: reset with every channel pending
    for (int ch = 0; ch < N; ch++) do_write(3'(ch), 32'hC0 + 32'(ch));
    reset = 1; step(); reset = 0;
    check_outputs("t6");
    chk("t6_valid_c", out_valid, 4'h0);
    chk("t6_data_c", out_data, 128'h0);
    read_chk("t6_unmapped", 3'(N + 2));
    chk("t6_unmapped_c", readdata, 32'h0);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      in_ready   = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_read", readdata, model_read(address));
      step();
      check_outputs("rnd");
    end
    reset = 0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
